// File: rtl/board_commit.sv
// board_commit -- board-state owner for the 2048 game logic.
//
// Sits behind the 4:1 direction-select mux. On move_req it waits MUX_LAT
// cycles for next_board to settle. It commits next_board only when it
// differs from the current board. It then spawns a tile in a pseudo-random
// empty cell and evaluates won/lost. On new_game it clears the board and
// spawns two tiles.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   new_game          pulse: clear board, spawn two tiles (wins over move_req)
//   move_req          pulse: commit next_board as a move
//   next_board[r][c]  moved board from the mux, literal tile values, 0 = empty
//   board[r][c]       current committed board (fed back to the move engines)
//   busy              request in flight
//   done / no_move    completion pulse / completion with an unchanged board
//   won / lost        levels, refreshed when a request completes
//   move_count        committed moves since reset/new_game, saturating
//
// Optional build macro: SPAWN_FOUR_EN -- roughly 1 in 16 spawns are 4s.

// Per-cell status: empty, holds the win value, or matches its right/down
// neighbour (a merge is still possible).
module board_commit_cell #(
  parameter logic [11:0] WIN_VALUE = 12'd2048
) (
  input  logic [11:0] val,
  input  logic [11:0] right,
  input  logic [11:0] down,
  input  logic        has_right,
  input  logic        has_down,
  output logic        empty,
  output logic        win,
  output logic        pair
);
  assign empty = (val == 12'd0);
  assign win   = (val == WIN_VALUE);
  assign pair  = !empty && ((has_right && val == right) || (has_down && val == down));
endmodule

module board_commit #(
  parameter int          MUX_LAT   = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [11:0] WIN_VALUE = 12'd2048
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    new_game,
  input  logic                    move_req,
  input  logic [3:0][3:0][11:0]   next_board,
  output logic [3:0][3:0][11:0]   board,
  output logic                    busy,
  output logic                    done,
  output logic                    no_move,
  output logic                    won,
  output logic                    lost,
  output logic [15:0]             move_count
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_COMPARE = 3'd2;
  localparam logic [2:0] S_SPAWN   = 3'd3;
  localparam logic [2:0] S_CHECK   = 3'd4;

  localparam int WCW = (MUX_LAT > 1) ? $clog2(MUX_LAT) : 1;

  logic [2:0]     state;
  logic [15:0]    lfsr;
  logic [WCW-1:0] wait_cnt;
  logic [1:0]     spawn_left;
  logic [3:0]     ptr;        // spawn scan pointer, idx = 4*r + c
  logic [3:0]     probe_cnt;  // consecutive occupied probes
  logic [11:0]    spawn_val;
  logic [15:0]    cell_empty, cell_win, cell_pair;

  // Fibonacci LFSR, taps 16,14,13,11.
  logic lfsr_fb;
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

`ifdef SPAWN_FOUR_EN
  assign spawn_val = (lfsr[7:4] == 4'h0) ? 12'd4 : 12'd2;
`else
  assign spawn_val = 12'd2;
`endif

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      logic [11:0] rv, dv;
      if (c < 3) begin : g_r
        assign rv = board[r][c+1];
      end else begin : g_nr
        assign rv = '0;
      end
      if (r < 3) begin : g_d
        assign dv = board[r+1][c];
      end else begin : g_nd
        assign dv = '0;
      end
      board_commit_cell #(.WIN_VALUE(WIN_VALUE)) u_cell (
        .val       (board[r][c]),
        .right     (rv),
        .down      (dv),
        .has_right (c < 3),
        .has_down  (r < 3),
        .empty     (cell_empty[4*r+c]),
        .win       (cell_win[4*r+c]),
        .pair      (cell_pair[4*r+c])
      );
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      board      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      no_move    <= 1'b0;
      won        <= 1'b0;
      lost       <= 1'b0;
      move_count <= '0;
      lfsr       <= LFSR_SEED;
      wait_cnt   <= '0;
      spawn_left <= '0;
      ptr        <= '0;
      probe_cnt  <= '0;
    end else begin
      lfsr    <= {lfsr[14:0], lfsr_fb};
      done    <= 1'b0;
      no_move <= 1'b0;
      case (state)
        S_IDLE: begin
          // busy is held through the done cycle and drops here.
          busy <= 1'b0;
          if (new_game) begin
            board      <= '0;
            won        <= 1'b0;
            lost       <= 1'b0;
            move_count <= '0;
            spawn_left <= 2'd2;
            ptr        <= lfsr[3:0];
            probe_cnt  <= '0;
            busy       <= 1'b1;
            state      <= S_SPAWN;
          end else if (move_req) begin
            wait_cnt <= '0;
            busy     <= 1'b1;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + WCW'(1);
          if (wait_cnt == WCW'(MUX_LAT - 1)) state <= S_COMPARE;
        end
        S_COMPARE: begin
          if (next_board == board) begin
            done    <= 1'b1;
            no_move <= 1'b1;
            state   <= S_IDLE;
          end else begin
            board <= next_board;
            if (move_count != 16'hFFFF) move_count <= move_count + 16'd1;
            spawn_left <= 2'd1;
            ptr        <= lfsr[3:0];
            probe_cnt  <= '0;
            state      <= S_SPAWN;
          end
        end
        S_SPAWN: begin
          if (cell_empty[ptr]) begin
            board[ptr[3:2]][ptr[1:0]] <= spawn_val;
            spawn_left <= spawn_left - 2'd1;
            if (spawn_left == 2'd1) begin
              state <= S_CHECK;
            end else begin
              ptr       <= lfsr[3:0];
              probe_cnt <= '0;
            end
          end else begin
            // Linear probe; a full lap means the board is full, give up.
            ptr <= ptr + 4'd1;
            if (probe_cnt == 4'd15) state <= S_CHECK;
            else probe_cnt <= probe_cnt + 4'd1;
          end
        end
        S_CHECK: begin
          won   <= |cell_win;
          lost  <= ~(|cell_empty) & ~(|cell_pair);
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_board_commit.sv
// Self-checking bench for board_commit: transaction-level reference model
// (per accepted request, predicts done cycle, final board, flags), a
// per-cycle compare process, directed scenarios and a randomized phase.
module tb_board_commit;
  localparam int          MUX_LAT = 2;
  localparam logic [15:0] SEED    = 16'hACE1;

  typedef logic [3:0][3:0][11:0] brd_t;

  logic        clk = 1'b0, rst = 1'b1, new_game = 1'b0, move_req = 1'b0;
  brd_t        next_board = '0;
  brd_t        board;
  logic        busy, done, no_move, won, lost;
  logic [15:0] move_count;

  board_commit dut (
    .clk(clk), .rst(rst), .new_game(new_game), .move_req(move_req),
    .next_board(next_board), .board(board), .busy(busy), .done(done),
    .no_move(no_move), .won(won), .lost(lost), .move_count(move_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] adv(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  function automatic logic [11:0] spawn_value(input logic [15:0] lf);
`ifdef SPAWN_FOUR_EN
    return (lf[7:4] == 4'h0) ? 12'd4 : 12'd2;
`else
    return 12'd2;
`endif
  endfunction

  function automatic int nz(input brd_t b);
    int n = 0;
    for (int i = 0; i < 16; i++) if (b[i/4][i%4] != 0) n++;
    return n;
  endfunction

  function automatic int cnt_val(input brd_t b, input logic [11:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) if (b[i/4][i%4] == v) n++;
    return n;
  endfunction

  function automatic bit f_won(input brd_t b);
    return cnt_val(b, 12'd2048) != 0;
  endfunction

  function automatic bit f_lost(input brd_t b);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (b[r][c] == 0) return 1'b0;
        if (c < 3 && b[r][c] == b[r][c+1]) return 1'b0;
        if (r < 3 && b[r][c] == b[r+1][c]) return 1'b0;
      end
    return 1'b1;
  endfunction

  // Spawn nsp tiles starting at cell p0 in cycle t0 (lfsr value lf0 then);
  // returns the cycle in which done is visible.
  task automatic spawn_model(inout brd_t b, input int nsp, input logic [3:0] p0,
                             input logic [15:0] lf0, input int t0, output int d);
    int p = p0, sl = nsp, probes = 0, t = t0;
    logic [15:0] lf = lf0;
    bit fin = 0;
    while (!fin) begin
      if (b[p/4][p%4] == 0) begin
        b[p/4][p%4] = spawn_value(lf);
        sl--; probes = 0;
        if (sl == 0) fin = 1; else p = lf[3:0];
      end else begin
        p = (p + 1) % 16; probes++;
        if (probes == 16) fin = 1;
      end
      t++; lf = adv(lf);
    end
    d = t + 1;  // t is the evaluation cycle
  endtask

  brd_t        m_board = '0;
  bit          m_won = 0, m_lost = 0, p_won = 0, p_lost = 0, tr_ng = 0, tr_nm = 0;
  int          m_mc = 0, p_mc = 0, tA = -1, tD = -1;
  logic [15:0] m_lfsr = SEED;

  initial forever begin
    brd_t b; int d; logic [15:0] l3;
    @(posedge clk);
    if (rst) begin
      m_lfsr = SEED; m_board = '0; m_won = 0; m_lost = 0; m_mc = 0;
      tA = -1; tD = -1; tr_ng = 0; tr_nm = 0;
    end else begin
      if (cyc >= tD && (new_game || move_req)) begin
        p_won = m_won; p_lost = m_lost; p_mc = m_mc; tA = cyc;
        if (new_game) begin
          tr_ng = 1; tr_nm = 0; b = '0; m_mc = 0;
          spawn_model(b, 2, m_lfsr[3:0], adv(m_lfsr), cyc + 1, d);
          tD = d; m_board = b; m_won = f_won(b); m_lost = f_lost(b);
        end else begin
          tr_ng = 0;
          if (next_board == m_board) begin
            tr_nm = 1; tD = cyc + MUX_LAT + 2;
          end else begin
            tr_nm = 0; b = next_board;
            if (m_mc < 65535) m_mc++;
            l3 = m_lfsr;
            for (int k = 0; k <= MUX_LAT; k++) l3 = adv(l3);  // lfsr in compare cycle
            spawn_model(b, 1, l3[3:0], adv(l3), cyc + MUX_LAT + 2, d);
            tD = d; m_board = b; m_won = f_won(b); m_lost = f_lost(b);
          end
        end
      end
      m_lfsr = adv(m_lfsr);
    end
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    bit idle, ew, el; int emc;
    @(negedge clk);
    if (rst) begin
      chk("rst_board", board, '0);
      chk("rst_flags", {busy, done, no_move, won, lost}, 5'b0);
      chk("rst_mc", move_count, 16'd0);
    end else begin
      idle = (cyc >= tD);
      chk("busy", busy, (cyc > tA && cyc <= tD));
      chk("done", done, (cyc == tD));
      chk("no_move", no_move, (cyc == tD && tr_nm));
      ew  = idle ? m_won  : (tr_ng ? 1'b0 : p_won);
      el  = idle ? m_lost : (tr_ng ? 1'b0 : p_lost);
      emc = idle ? m_mc : (tr_ng ? 0 : (cyc >= tA + MUX_LAT + 2 ? m_mc : p_mc));
      chk("won", won, ew);
      chk("lost", lost, el);
      chk("move_count", move_count, emc[15:0]);
      if (idle) chk("board", board, m_board);
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input bit ng, input bit mv);
    @(posedge clk); #1;
    new_game = ng; move_req = mv;
    @(posedge clk); #1;
    new_game = 0; move_req = 0;
  endtask

  task automatic wait_done(output int lat, output bit nm);
    bit seen = 0;
    lat = 0; nm = 0;
    while (!seen && lat < 80) begin
      @(negedge clk); lat++;
      if (done) begin seen = 1; nm = no_move; end
    end
    chk("done_seen", seen, 1'b1);
  endtask

  function automatic logic [11:0] rand_tile();
    int r = $urandom_range(0, 11);
    return (r == 0) ? 12'd0 : 12'(1 << r);
  endfunction

  initial begin
    int lat, dn; bit nm; brd_t nb;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst = 0;

    // new game: two 2-tiles, bounded latency
    pulse(1, 0); wait_done(lat, nm);
    chk("ng_lat_le34", lat <= 34, 1'b1);
    chk("ng_tiles", nz(board), 2);
`ifndef SPAWN_FOUR_EN
    chk("ng_twos", cnt_val(board, 12'd2), 2);
`endif

    // unchanged board: no_move with done at acceptance + MUX_LAT + 2
    next_board = m_board;
    pulse(0, 1); wait_done(lat, nm);
    chk("nm_lat", lat, 4);
    chk("nm_flag", nm, 1'b1);
    chk("nm_mc", move_count, 16'd0);

    // setup board: row0 = {2,2,0,0}, one more hole at [3][3]
    nb = '0;
    nb[0][0] = 12'd2;   nb[0][1] = 12'd2;
    nb[1] = {12'd64, 12'd32, 12'd16, 12'd8};
    nb[2] = {12'd1024, 12'd512, 12'd256, 12'd128};
    nb[3] = {12'd0, 12'd32, 12'd16, 12'd8};
    next_board = nb;
    pulse(0, 1); wait_done(lat, nm);
    chk("setup_mc", move_count, 16'd1);

    // merge row0 -> {4,0,0,0}; exactly one new 2 appears
    nb = m_board;
    for (int i = 0; i < 16; i++) if (nb[i/4][i%4] == 12'd2) nb[i/4][i%4] = 12'd0;
    nb[0][0] = 12'd4;
    next_board = nb;
    pulse(0, 1); wait_done(lat, nm);
    chk("merge_cell", board[0][0], 12'd4);
    chk("merge_tiles", nz(board), 13);
`ifndef SPAWN_FOUR_EN
    chk("merge_twos", cnt_val(board, 12'd2), 1);
`endif
    chk("merge_mc", move_count, 16'd2);

    // 2048 appears -> won
    nb = m_board; nb[1][1] = 12'd2048;
    next_board = nb;
    pulse(0, 1); wait_done(lat, nm);
    chk("win_won", won, 1'b1);

    // full 2/4 checkerboard -> spawn abandoned, lost
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) nb[r][c] = ((r + c) % 2) ? 12'd4 : 12'd2;
    next_board = nb;
    pulse(0, 1); wait_done(lat, nm);
    chk("cb_lost", lost, 1'b1);
    chk("cb_won", won, 1'b0);
    chk("cb_mc", move_count, 16'd4);

    // move_req + new_game together: new_game wins
    next_board = '0;
    pulse(1, 1); wait_done(lat, nm);
    chk("both_mc", move_count, 16'd0);
    chk("both_tiles", nz(board), 2);

    // move_req while busy is dropped: only one done
    nb = m_board; nb[3][3] = 12'd8; nb[3][2] = 12'd16;
    next_board = nb;
    pulse(0, 1); pulse(0, 1); wait_done(lat, nm);
    dn = 0;
    repeat (20) begin @(negedge clk); if (done) dn++; end
    chk("extra_done", dn, 0);

    // reset during spawn
    pulse(1, 0);
    @(posedge clk); #1 rst = 1;
    #1;
    chk("rst_mid_board", board, '0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_mc", move_count, 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst = 0;
    pulse(1, 0); wait_done(lat, nm);
    chk("rst_ng_lat", lat <= 34, 1'b1);
    chk("rst_ng_tiles", nz(board), 2);

    // randomized phase
    for (int it = 0; it < 150; it++) begin
      int op = $urandom_range(0, 9);
      nb = m_board;
      if (op == 9) begin
        for (int i = 0; i < 16; i++) nb[i/4][i%4] = 12'(1 << $urandom_range(1, 11));
      end else if (op >= 4) begin
        for (int k = 0; k < $urandom_range(1, 4); k++) begin
          int idx = $urandom_range(0, 15);
          nb[idx/4][idx%4] = rand_tile();
        end
      end
      next_board = nb;
      if (op == 0)      pulse(1, 0);
      else if (op == 3) pulse(1, 1);
      else              pulse(0, 1);
      if ($urandom_range(0, 4) == 0) pulse(0, 1);  // dropped while busy
      wait_done(lat, nm);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
